// File: rtl/bcd_adder_serial.sv
// Serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with valid/ready handshakes on the operand and result sides.
module bcd_adder_serial #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] a,
  input  logic [4*NDIGITS-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] sum,
  output logic                 cout,
  output logic                 error
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, acc_reg, sum_reg;
  logic [CW-1:0]   cnt_reg;
  logic            sub_reg, carry_reg, bad_reg, cout_reg, error_reg;

  logic [NDIGITS-1:0] digit_bad;
  logic               in_err;

  // Validity of every incoming digit, evaluated only at the accept edge.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_chk
      assign digit_bad[gi] = (a[4*gi+3:4*gi] > 4'd9) || (b[4*gi+3:4*gi] > 4'd9);
    end
  endgenerate
  assign in_err = |digit_bad;

  logic [3:0]   bd, s_dig;
  logic [4:0]   raw;
  logic         c_next;
  logic         last_dig;
  logic [W+3:0] shifted;
  logic [W-1:0] acc_next;

  // Operands shift right so the current digit is always in the low nibble;
  // result digits enter at the top and settle into place after NDIGITS steps.
  always_comb begin
    bd    = sub_reg ? (4'd9 - b_reg[3:0]) : b_reg[3:0];
    raw   = {1'b0, a_reg[3:0]} + {1'b0, bd} + {4'd0, carry_reg};
    s_dig = raw[3:0];
    c_next = 1'b0;
    if (raw > 5'd9) begin
      s_dig  = 4'(raw - 5'd10);
      c_next = 1'b1;
    end
    shifted  = {s_dig, acc_reg} >> 4;
    acc_next = shifted[W-1:0];
    last_dig = (cnt_reg == LAST_DIG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_dig)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      bad_reg   <= 1'b0;
      cout_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          a_reg     <= a;
          b_reg     <= b;
          sub_reg   <= sub;
          carry_reg <= sub | cin;
          bad_reg   <= in_err;
          cnt_reg   <= '0;
        end
        RUN: begin
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          carry_reg <= c_next;
          acc_reg   <= acc_next;
          cnt_reg   <= cnt_reg + CW'(1);
          // Visible outputs change only on the final digit edge.
          if (last_dig) begin
            sum_reg   <= bad_reg ? '0 : acc_next;
            cout_reg  <= c_next & ~bad_reg;
            error_reg <= bad_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Scoreboard bench for bcd_adder_serial: decimal-integer reference model,
// directed and random operands, backpressure and mid-operation reset.
module tb_bcd_adder_serial;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, error;

  bcd_adder_serial #(.NDIGITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   bp_cnt = 0;
  bit   prev_valid = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int pow10n();
    int p = 1;
    for (int i = 0; i < N; i++) p = p * 10;
    return p;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r = '0;
    int t = x;
    for (int i = 0; i < N; i++) begin
      r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) if (v[4*i+:4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: decimal integer arithmetic, ten's complement on borrow.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin, input logic tsub);
    exp_t e;
    int ai, bi, r, p;
    p = pow10n();
    e.acc_cyc = 0;
    e.err = has_bad(ta) | has_bad(tb_);
    if (e.err) begin
      e.sum = '0;
      e.cout = 1'b0;
    end else begin
      ai = bcd2int(ta);
      bi = bcd2int(tb_);
      if (tsub) begin
        e.cout = (ai >= bi);
        r = (ai >= bi) ? ai - bi : p + ai - bi;
      end else begin
        r = ai + bi + int'(tcin);
        e.cout = (r >= p);
        r = r % p;
      end
      e.sum = int2bcd(r);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[4*i+:4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0) v[4*$urandom_range(0, N-1)+:4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                       input logic tsub, input int hold, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    e = model(ta, tb_, tcin, tsub);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    if (hold > 0) begin
      bp_cnt = hold;
      out_ready = 1'b0;
    end
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    in_valid = 1'b0;
    a = rand_bcd(0); b = rand_bcd(0);
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
  endtask

  // Monitor: pops on the first cycle of each result, then checks it holds.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
          cur = '{sum: '0, cout: 1'b0, err: 1'b0, acc_cyc: 0};
        end else begin
          cur = sb.pop_front();
          chk("sum", {16'd0, sum}, {16'd0, cur.sum});
          chk("cout", {31'd0, cout}, {31'd0, cur.cout});
          chk("error", {31'd0, error}, {31'd0, cur.err});
          chk("latency", cyc - cur.acc_cyc, N);
        end
      end else if (out_valid) begin
        chk("hold_sum", {16'd0, sum}, {16'd0, cur.sum});
        chk("hold_cout", {31'd0, cout}, {31'd0, cur.cout});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end else if (prev_valid) begin
        chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
      end
      if (out_valid && bp_cnt > 0) begin
        bp_cnt--;
        if (bp_cnt == 0) out_ready = 1'b1;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout_err", {30'd0, cout, error}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h1234, 16'h8766, 0, 0, 0, 1);
    issue(16'h9999, 16'h0000, 1, 0, 0, 1);
    issue(16'h0450, 16'h0275, 0, 0, 0, 1);
    issue(16'h5000, 16'h1234, 1, 1, 0, 1);
    issue(16'h1234, 16'h5000, 0, 1, 0, 1);
    issue(16'h0042, 16'h0042, 0, 1, 0, 1);
    issue(16'h12A4, 16'h0001, 0, 0, 0, 1);
    issue(16'h0001, 16'h0001, 0, 0, 0, 1);

    // Backpressure with a stray in_valid during RUN/DONE.
    issue(16'h0123, 16'h0456, 1, 0, 3, 1);
    a = 16'h9999; b = 16'h9999; in_valid = 1'b1;
    @(negedge clk);
    chk("run_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Mid-operation reset after two digits, with nonzero prior outputs.
    issue(16'h0450, 16'h0275, 0, 0, 0, 1);
    drain();
    issue(16'h1111, 16'h2222, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_cout_err", {30'd0, cout, error}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0999, 16'h0001, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = rand_bcd(1);
      rb = rand_bcd(1);
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_adder_serial.md
Name: bcd_adder_serial

Overview:
N-digit packed-BCD adder/subtractor that processes one decimal digit per clock, least significant digit first.
It extends the single-digit BCD adder to a parametrised operand width, adds a subtract mode (ten's complement), and adds valid/ready handshakes on both input and output.
It sits between operand-producing logic and display/accumulator logic in the decimal datapath.

Parameters:
NDIGITS, 4, number of BCD digits per operand (>=1); operand/result width is 4*NDIGITS bits.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand set presented.
in_ready  output  1  block can accept an operand set.
a  input  4*NDIGITS  packed BCD operand A; digit i is a[4i+3:4i].
b  input  4*NDIGITS  packed BCD operand B.
cin  input  1  decimal carry-in, add mode only.
sub  input  1  0 = A+B+cin, 1 = A-B.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  4*NDIGITS  packed BCD result.
cout  output  1  decimal carry out of the top digit.
error  output  1  at least one digit of a or b was >9 when the operand set was accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0, sum=0, cout=0, error=0, digit counter=0; in_ready=1 once in IDLE.
- States:
  - IDLE -> RUN on (in_valid && in_ready).
  - RUN -> DONE when the counter reaches NDIGITS-1 and that digit is processed.
  - DONE -> IDLE on out_ready.
- in_ready = (state==IDLE). Inputs are ignored in RUN and DONE.
- Accept (IDLE, handshake):
  - Latch a, b, sub.
  - Set the running carry c to sub ? 1 : cin. cin is ignored when sub=1.
  - Compute error from all digits of a and b. Counter = 0.
- RUN, per cycle for digit i = counter:
  - Effective B digit: bd = sub ? (9 - b_i) : b_i.
  - 5-bit raw sum d = a_i + bd + c.
  - If d>9: s_i = d-10 and c=1; else s_i = d and c=0.
  - Write s_i into sum digit i. Increment the counter.
- Latency: the handshake at rising edge k produces out_valid=1 after edge k+NDIGITS. sum, cout and error update together on that edge.
- cout:
  - Add mode: final c.
  - Sub mode: final c, where 1 means A>=B and sum=A-B; 0 means A<B and sum=10^NDIGITS+A-B (ten's complement).
- Error: if error=1, sum is forced to all zeros and cout to 0 on the final edge. The latency is unchanged.
- DONE:
  - out_valid=1. sum, cout and error stay stable until the edge where out_ready=1.
  - On that edge out_valid goes to 0 and the state returns to IDLE.
  - A new operand cannot be accepted on that same edge (one bubble cycle).
- sum, cout and error keep their last values after out_valid drops.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-operation aborts it immediately: no out_valid is produced and all outputs take their reset values.
- NDIGITS=1 gives a one-cycle RUN and behaves as a registered single-digit adder.

Test Plan:
- NDIGITS=4; a=0x1234, b=0x8766, sub=0, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, error=0.
- a=0x9999, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1. Then a=0x0450, b=0x0275, cin=0 -> sum=0x0725, cout=0.
- sub=1: a=0x5000, b=0x1234 -> sum=0x3766, cout=1. Then a=0x1234, b=0x5000 -> sum=0x6234, cout=0. Then a=b=0x0042 -> sum=0x0000, cout=1.
- a=0x12A4, b=0x0001 -> error=1, sum=0x0000, cout=0, still after 4 cycles. A following valid op -> error=0.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> outputs held stable; in_ready=0 throughout and an in_valid pulse in RUN/DONE is ignored. out_ready=1 -> next-cycle in_ready=1.
- Drop rst_n during RUN (after 2 digits) -> out_valid, sum, cout and error read 0 asynchronously. After release, a fresh op completes normally.
